// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline memory stage.
package mips_pkg;

  localparam int unsigned BITS_SIZE = 32;
  localparam int unsigned MEM_DEPTH = 256;

  // Access-size codes; 2'b11 is decoded as a word access.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/data_memory.sv
// Word-organised data memory: byte-enable synchronous write, two asynchronous reads.
module data_memory #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned BITS_ADDR = 8
) (
  input  logic                 i_clk,
  input  logic [3:0]           i_we,
  input  logic [BITS_ADDR-1:0] i_addr,
  input  logic [31:0]          i_wdata,
  output logic [31:0]          o_rdata,
  input  logic [BITS_ADDR-1:0] i_debug_addr,
  output logic [31:0]          o_debug_data
);

  // Zero at elaboration; reset leaves the contents alone.
  logic [31:0] mem_q [MEM_DEPTH] = '{default: '0};

  // Commit only the enabled byte lanes.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we[i]) begin
        mem_q[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  assign o_rdata      = mem_q[i_addr];
  assign o_debug_data = mem_q[i_debug_addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: sized stores/loads, branch resolution, sticky status flags.
module mem_stage
  import mips_pkg::*;
#(
  parameter int unsigned BITS_SIZE = mips_pkg::BITS_SIZE,
  parameter int unsigned MEM_DEPTH = mips_pkg::MEM_DEPTH,
  parameter int unsigned BITS_ADDR = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_step,
  input  logic [BITS_SIZE-1:0] i_alu,
  input  logic [BITS_SIZE-1:0] i_register_2,
  input  logic                 i_zero,
  input  logic                 i_branch,
  input  logic                 i_neq_branch,
  input  logic                 i_mem_write,
  input  logic                 i_mem_read,
  input  logic [1:0]           i_datamem_size,
  input  logic                 i_zero_extend,
  input  logic                 i_halt,
  input  logic [BITS_ADDR-1:0] i_debug_addr,
  output logic [BITS_SIZE-1:0] o_read_data,
  output logic                 o_pc_src,
  output logic [BITS_SIZE-1:0] o_debug_data,
  output logic                 o_misaligned,
  output logic                 o_halted
);

  logic [BITS_ADDR-1:0] word_idx;
  logic [1:0]           offset;
  logic                 misaligned;
  logic [3:0]           be;
  logic [3:0]           we;
  logic [31:0]          wdata;
  logic [31:0]          raw;
  logic [31:0]          shifted;
  logic [7:0]           byte_sel;
  logic [15:0]          half_sel;
  logic                 halted_q, halted_d;
  logic                 misaligned_q, misaligned_d;

  // Address bits above the memory span are ignored, so addresses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^i_alu[BITS_SIZE-1:BITS_ADDR+2];

  assign word_idx = i_alu[BITS_ADDR+1:2];
  assign offset   = i_alu[1:0];

  // Half needs even offset, word needs offset 0.
  always_comb begin
    misaligned = 1'b0;
    case (i_datamem_size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = offset[0];
      default:   misaligned = (offset != 2'b00);
    endcase
  end

  // Steer store data onto byte lanes and pick the lane enables.
  always_comb begin
    be    = 4'b0000;
    wdata = '0;
    case (i_datamem_size)
      SIZE_BYTE: begin
        be    = 4'b0001 << offset;
        wdata = {4{i_register_2[7:0]}};
      end
      SIZE_HALF: begin
        be    = offset[1] ? 4'b1100 : 4'b0011;
        wdata = {2{i_register_2[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = i_register_2[31:0];
      end
    endcase
  end

  assign we = (i_step && i_mem_write && !misaligned && !halted_q) ? be : 4'b0000;

  data_memory #(
    .MEM_DEPTH (MEM_DEPTH),
    .BITS_ADDR (BITS_ADDR)
  ) u_data_memory (
    .i_clk        (i_clk),
    .i_we         (we),
    .i_addr       (word_idx),
    .i_wdata      (wdata),
    .o_rdata      (raw),
    .i_debug_addr (i_debug_addr),
    .o_debug_data (o_debug_data)
  );

  assign shifted  = raw >> {offset, 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = offset[1] ? raw[31:16] : raw[15:0];

  // Select and extend the load result; zero when idle or misaligned.
  always_comb begin
    o_read_data = '0;
    if (i_mem_read && !misaligned) begin
      case (i_datamem_size)
        SIZE_BYTE: o_read_data = i_zero_extend ? {{(BITS_SIZE-8){1'b0}}, byte_sel}
                                               : {{(BITS_SIZE-8){byte_sel[7]}}, byte_sel};
        SIZE_HALF: o_read_data = i_zero_extend ? {{(BITS_SIZE-16){1'b0}}, half_sel}
                                               : {{(BITS_SIZE-16){half_sel[15]}}, half_sel};
        default:   o_read_data = raw;
      endcase
    end
  end

  assign o_pc_src = (i_branch && i_zero) || (i_neq_branch && !i_zero);

  // Sticky flags only move on stepped cycles.
  always_comb begin
    halted_d     = halted_q;
    misaligned_d = misaligned_q;
    if (i_step) begin
      if (i_halt) halted_d = 1'b1;
      if ((i_mem_read || i_mem_write) && misaligned) misaligned_d = 1'b1;
    end
  end

  // Flag registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      halted_q     <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      halted_q     <= halted_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign o_halted     = halted_q;
  assign o_misaligned = misaligned_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: byte-array reference model plus directed literals.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst, step, zero, br, nbr, mw, mr, zx, halt;
  logic [31:0] alu, rs2;
  logic [1:0]  size;
  logic [7:0]  dbg_addr;
  logic [31:0] rd, dbg;
  logic        pc_src, mis, halted;

  int total = 0;
  int bad   = 0;

  // Reference state: memory as a flat little-endian byte array.
  logic [7:0] bm [1024];
  logic       halted_m, mis_m;

  always #5 clk = ~clk;

  mem_stage dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_step         (step),
    .i_alu          (alu),
    .i_register_2   (rs2),
    .i_zero         (zero),
    .i_branch       (br),
    .i_neq_branch   (nbr),
    .i_mem_write    (mw),
    .i_mem_read     (mr),
    .i_datamem_size (size),
    .i_zero_extend  (zx),
    .i_halt         (halt),
    .i_debug_addr   (dbg_addr),
    .o_read_data    (rd),
    .o_pc_src       (pc_src),
    .o_debug_data   (dbg),
    .o_misaligned   (mis),
    .o_halted       (halted)
  );

  function automatic int baddr();
    return int'(alu % 1024);
  endfunction

  function automatic logic [31:0] m_word(int idx);
    return {bm[idx*4+3], bm[idx*4+2], bm[idx*4+1], bm[idx*4]};
  endfunction

  function automatic logic m_mis();
    int a = baddr();
    if (size == 2'd0) return 1'b0;
    if (size == 2'd1) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  function automatic logic [31:0] m_load();
    int a = baddr();
    logic [31:0] v;
    if (!mr || m_mis()) return 32'd0;
    if (size == 2'd0) begin
      v = {24'd0, bm[a]};
      if (!zx && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = {16'd0, bm[a+1], bm[a]};
      if (!zx && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = m_word(a / 4);
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Compare every DUT output with the model.
  task automatic compare_model();
    chk("read_data", rd, m_load());
    chk("pc_src", {31'd0, pc_src}, {31'd0, (br && zero) || (nbr && !zero)});
    chk("debug_data", dbg, m_word(int'(dbg_addr)));
    chk("misaligned", {31'd0, mis}, {31'd0, mis_m});
    chk("halted", {31'd0, halted}, {31'd0, halted_m});
  endtask

  // Apply the clock-edge effects of the current inputs to the model.
  task automatic update_model();
    int a = baddr();
    logic old_halt = halted_m;
    if (step && mw && !m_mis() && !old_halt) begin
      if (size == 2'd0) begin
        bm[a] = rs2[7:0];
      end else if (size == 2'd1) begin
        bm[a] = rs2[7:0]; bm[a+1] = rs2[15:8];
      end else begin
        for (int k = 0; k < 4; k++) bm[a+k] = rs2[8*k +: 8];
      end
    end
    if (rst) begin
      halted_m = 1'b0;
      mis_m    = 1'b0;
    end else if (step) begin
      if (halt) halted_m = 1'b1;
      if ((mr || mw) && m_mis()) mis_m = 1'b1;
    end
  endtask

  // Inputs are set at the falling edge; check, then take the rising edge.
  task automatic step_cycle();
    #2;
    compare_model();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; step = 0; zero = 0; br = 0; nbr = 0; mw = 0; mr = 0; zx = 0; halt = 0;
    alu = 0; rs2 = 0; size = 2'd2; dbg_addr = 0;
  endtask

  task automatic store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    idle(); step = 1; mw = 1; alu = a; size = s; rs2 = d;
    step_cycle();
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] s, input logic z);
    idle(); mr = 1; alu = a; size = s; zx = z;
    #1;
  endtask

  initial begin
    foreach (bm[i]) bm[i] = 8'd0;
    halted_m = 1'b0;
    mis_m    = 1'b0;
    idle();
    rst = 1;
    @(negedge clk);
    step_cycle();
    rst = 1;
    step_cycle();
    idle();
    #1;
    chk("reset_halted", {31'd0, halted}, 32'd0);
    chk("reset_misaligned", {31'd0, mis}, 32'd0);
    step_cycle();

    // Word store / load and debug port.
    store(32'h10, 2'd2, 32'hDEAD_BEEF);
    load(32'h10, 2'd2, 1'b0); dbg_addr = 8'd4; #1;
    chk("lit_word_load", rd, 32'hDEAD_BEEF);
    chk("lit_word_debug", dbg, 32'hDEAD_BEEF);
    step_cycle();

    // Byte store over a zeroed word, both extensions.
    store(32'h10, 2'd2, 32'h0);
    store(32'h13, 2'd0, 32'h0000_0080);
    load(32'h13, 2'd0, 1'b0);
    chk("lit_byte_sext", rd, 32'hFFFF_FF80);
    step_cycle();
    load(32'h13, 2'd0, 1'b1);
    chk("lit_byte_zext", rd, 32'h0000_0080);
    step_cycle();
    load(32'h10, 2'd2, 1'b0);
    chk("lit_byte_word", rd, 32'h8000_0000);
    step_cycle();

    // Half store to the upper half.
    store(32'h22, 2'd1, 32'h0000_BEEF);
    load(32'h20, 2'd2, 1'b0);
    chk("lit_half_word", rd, 32'hBEEF_0000);
    step_cycle();
    load(32'h22, 2'd1, 1'b0);
    chk("lit_half_sext", rd, 32'hFFFF_BEEF);
    step_cycle();

    // Misaligned word store is dropped and flagged.
    store(32'h05, 2'd2, 32'h1234_5678);
    idle(); dbg_addr = 8'd1; #1;
    chk("lit_mis_flag", {31'd0, mis}, 32'd1);
    chk("lit_mis_nowrite", dbg, 32'd0);
    step_cycle();
    load(32'h01, 2'd1, 1'b0);
    chk("lit_mis_load", rd, 32'd0);
    step_cycle();

    // Branch resolution.
    idle(); br = 1; zero = 1; #1;
    chk("lit_beq_taken", {31'd0, pc_src}, 32'd1);
    idle(); nbr = 1; zero = 1; #1;
    chk("lit_bne_not", {31'd0, pc_src}, 32'd0);
    idle(); nbr = 1; zero = 0; #1;
    chk("lit_bne_taken", {31'd0, pc_src}, 32'd1);
    step_cycle();

    // Halt with concurrent store; later stores blocked; reset clears flag only.
    idle(); step = 1; halt = 1; mw = 1; alu = 32'h30; size = 2'd2; rs2 = 32'hCAFE_F00D;
    step_cycle();
    idle(); dbg_addr = 8'd12; #1;
    chk("lit_halt_flag", {31'd0, halted}, 32'd1);
    chk("lit_halt_store", dbg, 32'hCAFE_F00D);
    store(32'h34, 2'd2, 32'h1111_1111);
    idle(); dbg_addr = 8'd13; #1;
    chk("lit_halt_block", dbg, 32'd0);
    rst = 1;
    step_cycle();
    idle(); dbg_addr = 8'd12; #1;
    chk("lit_reset_halt", {31'd0, halted}, 32'd0);
    chk("lit_reset_keep", dbg, 32'hCAFE_F00D);
    step_cycle();

    // Randomised traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      rst  = ($urandom_range(0, 99) == 0);
      step = ($urandom_range(0, 9) != 0);
      alu  = (($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FC00) : 32'd0)
             | 32'($urandom_range(0, 127));
      rs2  = $urandom;
      zero = 1'($urandom_range(0, 1));
      br   = 1'($urandom_range(0, 1));
      nbr  = 1'($urandom_range(0, 1));
      zx   = 1'($urandom_range(0, 1));
      mr   = 1'($urandom_range(0, 1));
      mw   = !rst && ($urandom_range(0, 2) == 0);
      size = 2'($urandom_range(0, 3));
      halt = ($urandom_range(0, 299) == 0);
      dbg_addr = 8'($urandom_range(0, 31));
      step_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
